imem_boot_loader: RTL

- Boot-time sequencer for the byte-wide instruction memory.
- Accepts a byte stream over a valid/ready handshake and writes it into consecutive byte addresses from 0, one byte per accepted transfer.
- Holds the core stalled until the image is loaded, then hands the memory address port to the core fetch path.
- Sits between the external boot source, the instruction memory and the core PC.

---
 rtl/imem_boot_loader.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Boot-time byte loader for the instruction memory: streams an image into addresses 0..len-1,
// then releases the core. Define IMEM_BOOT_CHECKSUM_EN to require a trailing checksum byte.
module imem_boot_loader #(
  parameter int ADDR_BUS_WIDTH = 5,
  parameter int DATA_BUS_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_BUS_WIDTH:0]   len,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [7:0]                s_data,
  input  logic [ADDR_BUS_WIDTH-1:0] pc_a,
  output logic [ADDR_BUS_WIDTH-1:0] imem_a,
  output logic                      mem_we,
  output logic [7:0]                mem_wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      cpu_run,
  output logic                      err
);

  localparam int unsigned DEPTH_I = 2 ** ADDR_BUS_WIDTH;
  localparam logic [ADDR_BUS_WIDTH:0]   MEM_DEPTH = DEPTH_I[ADDR_BUS_WIDTH:0];
  localparam logic [ADDR_BUS_WIDTH:0]   CNT_ZERO  = {(ADDR_BUS_WIDTH+1){1'b0}};
  localparam logic [ADDR_BUS_WIDTH:0]   CNT_ONE   = {{ADDR_BUS_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_BUS_WIDTH-1:0] ADDR_ZERO = {ADDR_BUS_WIDTH{1'b0}};

  if ((DATA_BUS_WIDTH % 8) != 0) begin : g_width_chk
    $error("DATA_BUS_WIDTH must be a whole number of bytes");
  end

`ifdef IMEM_BOOT_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_DONE = 2'd2, ST_CHECK = 2'd3} state_e;
  localparam state_e ST_AFTER_LOAD = ST_CHECK;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_DONE = 2'd2} state_e;
  localparam state_e ST_AFTER_LOAD = ST_DONE;
`endif

  state_e                      state_q, state_d;
  logic [ADDR_BUS_WIDTH:0]     cnt_q, cnt_d;
  logic [ADDR_BUS_WIDTH:0]     len_q, len_d;
  logic [ADDR_BUS_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic                        we_q, we_d;
  logic [7:0]                  wdata_q, wdata_d;
  logic                        err_q, err_d;

  logic                        idle_like_s;
  logic                        start_ok_s;
  logic                        xfer_s;
  logic                        load_xfer_s;
  logic                        last_s;
  logic [ADDR_BUS_WIDTH:0]     cnt_inc_s;

  assign idle_like_s = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign start_ok_s  = (len != CNT_ZERO) && (len <= MEM_DEPTH);
  assign xfer_s      = s_valid && s_ready;
  assign load_xfer_s = xfer_s && (state_q == ST_LOAD);
  assign cnt_inc_s   = cnt_q + CNT_ONE;
  assign last_s      = load_xfer_s && (cnt_inc_s == len_q);

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] sum_plus_s;
  logic       chk_xfer_s;
  logic       chk_pass_s;

  assign sum_plus_s = sum_q + s_data;
  assign chk_xfer_s = xfer_s && (state_q == ST_CHECK);
  assign chk_pass_s = (sum_plus_s == 8'h00);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (start_ok_s) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (last_s) begin
          state_d = ST_AFTER_LOAD;
        end else begin
          state_d = ST_LOAD;
        end
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      ST_CHECK: begin
        if (chk_xfer_s) begin
          if (chk_pass_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      ST_CHECK: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
`endif
      ST_DONE: done = 1'b1;
      default: begin
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
      end
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    len_d     = len_q;
    wr_addr_d = wr_addr_q;
    we_d      = 1'b0;
    wdata_d   = wdata_q;
    err_d     = err_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    if (idle_like_s && start) begin
      if (start_ok_s) begin
        len_d     = len;
        cnt_d     = CNT_ZERO;
        wr_addr_d = ADDR_ZERO;
        err_d     = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
        sum_d     = 8'h00;
`endif
      end else begin
        err_d = 1'b1;
      end
    end else if (load_xfer_s) begin
      cnt_d     = cnt_inc_s;
      wr_addr_d = cnt_q[ADDR_BUS_WIDTH-1:0];
      we_d      = 1'b1;
      wdata_d   = s_data;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum_d     = sum_plus_s;
    end else if (chk_xfer_s && !chk_pass_s) begin
      err_d = 1'b1;
`endif
    end else begin
      we_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= CNT_ZERO;
      len_q     <= CNT_ZERO;
      wr_addr_q <= ADDR_ZERO;
      we_q      <= 1'b0;
      wdata_q   <= 8'h00;
      err_q     <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum_q     <= 8'h00;
`endif
    end else begin
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      wr_addr_q <= wr_addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;
  assign cpu_run   = done;
  // The final image byte is written in the first DONE cycle, so a pending write keeps the port.
  assign imem_a    = (cpu_run && !we_q) ? pc_a : wr_addr_q;

endmodule
